// File: rtl/raybox_fixed_pkg.sv
// Shared fixed-point format constants, Newton-Raphson seed constants and the
// reciprocal unit state encoding.
package raybox_fixed_pkg;

   localparam int FIX_Q_M = 12;
   localparam int FIX_Q_N = 12;
   localparam int FIX_W   = FIX_Q_M + FIX_Q_N;

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      ITER,
      DENORM,
      DONE
   } recip_state_t;

   // num/17 scaled by 2^frac, rounded to nearest
   function automatic logic [63:0] seed_const(input int num, input int frac);
      logic [63:0] scaled;
      scaled = 64'(num) << frac;
      return (scaled + 64'd8) / 64'd17;
   endfunction

   localparam logic [63:0] SEED_48 = seed_const(48, FIX_W + 2);
   localparam logic [63:0] SEED_32 = seed_const(32, FIX_W + 2);

endpackage

// File: rtl/recip_unit_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module lzc #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0]               data,
   output logic [$clog2(WIDTH+1)-1:0]     count
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/recip_unit.sv
// Sequential signed fixed-point reciprocal: normalise to [0.5,1), seed and
// refine with Newton-Raphson, then denormalise, round and clamp.
module recip_unit
   import raybox_fixed_pkg::*;
#(
   parameter int Q_M   = FIX_Q_M,
   parameter int Q_N   = FIX_Q_N,
   parameter int ITERS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [Q_M+Q_N-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [Q_M+Q_N-1:0] out_data,
   output logic                      out_div0,
   output logic                      out_sat
);

   localparam int W   = Q_M + Q_N;
   localparam int F   = W + 2;              // internal fraction bits
   localparam int YW  = F + 1;              // y and (2 - d*y) both stay below 2
   localparam int LZW = $clog2(W + 1);
   localparam int CW  = $clog2(ITERS + 1);
   localparam int WW  = YW + 2 * Q_N + 1;

   localparam logic [YW:0]   C48     = (YW + 1)'(seed_const(48, F));
   localparam logic [YW-1:0] C32     = YW'(seed_const(32, F));
   localparam logic [YW:0]   TWO     = (YW + 1)'(1) << (F + 1);
   localparam logic [WW-1:0] MAX_MAG = (WW'(1) << (W - 1)) - WW'(1);

   typedef struct packed {
      logic         sat;
      logic [W-1:0] val;
   } clamp_t;

   function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
      return x[W-1] ? -x : x;
   endfunction

   function automatic logic [WW-1:0] round_shift(input logic [WW-1:0] val, input int sh);
      logic [WW-1:0] bias;
      bias = WW'(1) << (sh - 1);
      return (val + bias) >> sh;
   endfunction

   function automatic clamp_t saturate(input logic [WW-1:0] q, input logic neg, input logic zero);
      clamp_t       r;
      logic [W-1:0] lim;
      r.sat = zero || (q > MAX_MAG);
      lim   = r.sat ? MAX_MAG[W-1:0] : q[W-1:0];
      r.val = neg ? -lim : lim;
      return r;
   endfunction

   recip_state_t   state, next_state;
   logic [CW-1:0]  cnt;
   logic           accept;

   logic           sign_p0, zero_p0;
   logic [W-1:0]   mag_p0;
   logic [LZW-1:0] lz, lz_p1;
   logic [F-1:0]   d_p1;
   logic [YW-1:0]  y_p2;

   logic [YW-1:0]    mul_a, seed, dy, e, y_next;
   logic [YW+F-1:0]  prod_a;
   logic [2*YW-1:0]  prod_b;
   logic [WW-1:0]    q;
   clamp_t           res;

   lzc #(.WIDTH(W)) u_lzc (
      .data  (mag_p0),
      .count (lz)
   );

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = NORM;
         end
         NORM:   next_state = ITER;
         ITER:   if (cnt == CW'(ITERS)) next_state = DENORM;
         DENORM: next_state = DONE;
         DONE: begin
            in_ready = out_ready;
            if (out_ready) next_state = in_valid ? NORM : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // The first ITER cycle loads the seed; the remaining ITERS cycles refine it.
   always_comb begin
      mul_a  = (cnt == '0) ? C32 : y_p2;
      prod_a = mul_a * d_p1;
      seed   = YW'(C48 - (YW + 1)'(prod_a >> F));
      dy     = YW'(prod_a >> F);
      e      = YW'(TWO - {1'b0, dy});
      prod_b = y_p2 * e;
      y_next = YW'(prod_b >> F);
      q      = round_shift(WW'(y_p2) << (2 * Q_N), W + F - int'(lz_p1));
      res    = saturate(q, sign_p0, zero_p0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_div0  <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == NORM) cnt <= '0;
         else if (state == ITER) cnt <= cnt + 1'b1;
         if (state == DENORM) begin
            out_valid <= 1'b1;
            out_data  <= res.val;
            out_div0  <= zero_p0;
            out_sat   <= res.sat;
         end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_div0  <= 1'b0;
            out_sat   <= 1'b0;
         end
      end
   end

   // p0: accepted operand, p1: normalised divisor, p2: reciprocal estimate
   always_ff @(posedge clk) begin
      if (accept) begin
         sign_p0 <= in_data[W-1];
         zero_p0 <= (in_data == '0);
         mag_p0  <= magnitude(in_data);
      end
      if (state == NORM) begin
         d_p1  <= {mag_p0 << lz, 2'b00};
         lz_p1 <= lz;
      end
      if (state == ITER) y_p2 <= (cnt == '0) ? seed : y_next;
   end

endmodule

// File: tb/tb_recip_unit.sv
// Directed bench for recip_unit: exact power-of-two reciprocals, clamping,
// output stall with back-to-back acceptance, and reset during iteration.
module tb_recip_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic        out_div0;
   logic        out_sat;

   int n_cmp = 0;
   int n_bad = 0;

   recip_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_div0  (out_div0),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic send_op(input string tag, input logic [23:0] x);
      @(negedge clk);
      in_data  = x;
      in_valid = 1'b1;
      #1;
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 24'hA5A5A5;
   endtask

   task automatic wait_valid(output int lat);
      lat = 99;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic expect_result(input string tag, input logic [23:0] want,
                                input logic want_div0, input logic want_sat);
      int lat;
      wait_valid(lat);
      check_eq({tag, "_latency"}, 32'(lat), 32'd6);
      check_eq({tag, "_data"}, 32'(out_data), 32'(want));
      check_eq({tag, "_div0"}, 32'(out_div0), 32'(want_div0));
      check_eq({tag, "_sat"}, 32'(out_sat), 32'(want_sat));
   endtask

   task automatic run_op(input string tag, input logic [23:0] x, input logic [23:0] want,
                         input logic want_div0, input logic want_sat);
      send_op(tag, x);
      expect_result(tag, want, want_div0, want_sat);
      @(posedge clk);
      #1;
      check_eq({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_flags", {30'd0, out_div0, out_sat}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("one",     24'h001000, 24'h001000, 1'b0, 1'b0);
      run_op("two",     24'h002000, 24'h000800, 1'b0, 1'b0);
      run_op("half",    24'h000800, 24'h002000, 1'b0, 1'b0);
      run_op("neg4",    24'hFFC000, 24'hFFFC00, 1'b0, 1'b0);
      run_op("mostneg", 24'h800000, 24'hFFFFFE, 1'b0, 1'b0);
      run_op("zero",    24'h000000, 24'h7FFFFF, 1'b1, 1'b1);
      run_op("tiny",    24'h000001, 24'h7FFFFF, 1'b0, 1'b1);
      run_op("negtiny", 24'hFFFFFF, 24'h800001, 1'b0, 1'b1);
      run_op("three",   24'h003000, 24'h000555, 1'b0, 1'b0);
      run_op("negqtr",  24'hFFFC00, 24'hFFC000, 1'b0, 1'b0);

      // consumer stalls for 5 cycles, then takes the result while offering a new operand
      out_ready = 1'b0;
      send_op("stall", 24'h002000);
      expect_result("stall", 24'h000800, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_eq("stall_hold_valid", 32'(out_valid), 32'd1);
         check_eq("stall_hold_data", 32'(out_data), 32'h000800);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 24'h000800;
      #1;
      check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 24'h123456;
      check_eq("b2b_cleared", 32'(out_valid), 32'd0);
      expect_result("b2b", 24'h002000, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // reset while iterating
      send_op("abort", 24'h001000);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after", 24'hFFC000, 24'hFFFC00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/recip_unit.md
RECIP_UNIT -- requirements
Module: recip_unit

Interface
REQ-001 SHALL have parameter Q_M, default 12, meaning integer bits of the signed fixed-point format.
REQ-002 SHALL have parameter Q_N, default 12, meaning fraction bits; data width W = Q_M+Q_N (24 at default).
REQ-003 SHALL have parameter ITERS, default 3, meaning Newton-Raphson iteration count.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning operand offered.
REQ-007 SHALL have port in_ready, output, 1, meaning operand accepted when in_valid is also high at a clk edge.
REQ-008 SHALL have port in_data, input, W, signed Q_M.Q_N operand x.
REQ-009 SHALL have port out_valid, output, 1, meaning result available.
REQ-010 SHALL have port out_ready, input, 1, meaning consumer takes the result.
REQ-011 SHALL have port out_data, output, W, signed Q_M.Q_N value of 1/x.
REQ-012 SHALL have port out_div0, output, 1, meaning x was zero.
REQ-013 SHALL have port out_sat, output, 1, meaning the result was clamped.

Function
REQ-014 SHALL implement FSM states IDLE, NORM, ITER, DENORM, DONE.
REQ-015 SHALL assert in_ready in IDLE, and in DONE only while out_ready is high; deassert it in all other states.
REQ-016 SHALL, on acceptance, register the sign of x and |x| as a W-bit unsigned magnitude; x = -2^(W-1) gives magnitude 2^(W-1).
REQ-017 SHALL, in NORM (1 cycle), count the leading zeroes of the magnitude and left-shift it so that bit W-1 is set, giving d in [0.5,1); it SHALL record the shift count.
REQ-018 SHALL seed y0 = 48/17 - (32/17)*d, with both constants held at W+2 fraction bits.
REQ-019 SHALL, in ITER, perform exactly ITERS cycles, one per iteration: y <= y*(2 - d*y).
REQ-020 SHALL truncate full-width products back to the internal precision (at least W+2 fraction bits).
REQ-021 SHALL, in DENORM (1 cycle), right-shift y to undo normalisation and align it to Q_N, apply the sign by two's-complement negation, and clamp.
REQ-022 SHALL clamp out-of-range results to 2^(W-1)-1 for positive x or -(2^(W-1)-1) for negative x, and set out_sat.
REQ-023 SHALL, for x = 0, skip no states, produce 2^(W-1)-1, and set both out_div0 and out_sat.
REQ-024 SHALL produce results within ±2 LSB of the exact value 1/x truncated to Q_N.
REQ-025 SHALL have fixed latency: out_valid rises ITERS+3 edges after the accepting edge (6 at default).
REQ-026 SHALL, in DONE, hold out_valid, out_data and the flags stable until out_ready is high at a clk edge.
REQ-027 SHALL, on the DONE edge where out_ready is high, go to NORM if in_valid is also high (back-to-back acceptance), else to IDLE.
REQ-028 SHALL register all outputs, which are low or zero outside DONE except in_ready.
REQ-029 SHALL ignore in_data changes after acceptance.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-computation, immediately abort, enter IDLE, and clear out_valid, out_data, out_div0 and out_sat to 0.
REQ-031 SHALL drive in_ready to 1 one combinational delay after reset assertion, since the state is IDLE.
REQ-032 SHALL start its first acceptance at the first clk edge after reset deassertion.

Structure
REQ-033 SHALL take Q_M, Q_N, W and the seed constants from the shared package raybox_fixed_pkg.
REQ-034 SHALL instantiate the existing lzc module (WIDTH=W) for the NORM count as its only sub-module.
REQ-035 SHALL use two W+2-bit multipliers and no other arithmetic sub-modules; the target size is 120-400 lines of RTL.

Verification
REQ-036 SHALL test that x=0x001000 (1.0) gives 0x001000 after exactly 6 edges, with out_div0=0 and out_sat=0.
REQ-037 SHALL test that x=0x002000 (2.0) gives 0x000800, and x=0x000800 (0.5) gives 0x002000.
REQ-038 SHALL test that x=0xFFC000 (-4.0) gives 0xFFFC00, and x=0x800000 gives 0xFFFFFE.
REQ-039 SHALL test that x=0 gives 0x7FFFFF with out_div0=1 and out_sat=1, and x=0x000001 gives 0x7FFFFF with out_sat=1 and out_div0=0.
REQ-040 SHALL test that with out_ready held low for 5 cycles in DONE the output stays stable, then out_ready=1 with in_valid=1 causes immediate re-acceptance.
REQ-041 SHALL test that reset asserted during ITER gives IDLE, out_valid=0 and in_ready=1 at once, and that the next operand yields a correct result.
